// File: rtl/arm_pipe_pkg.sv
// Shared definitions for the EX-stage operand-forwarding logic.
//   SEL_*      : encoding of the 2-bit operand mux4 select
//   REG_ADDR_W : register-number width (r0..r15)
//   PC_REG     : register number that reads as PC and is never forwarded
//   fwd_entry_t: one tracked in-flight producer {valid, rd, is_load}
package arm_pipe_pkg;

  localparam int unsigned REG_ADDR_W = 4;

  localparam logic [REG_ADDR_W-1:0] PC_REG = 4'd15;

  localparam logic [1:0] SEL_REGFILE = 2'b00;
  localparam logic [1:0] SEL_EXMEM   = 2'b01;
  localparam logic [1:0] SEL_MEMWB   = 2'b10;
  localparam logic [1:0] SEL_PC      = 2'b11;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  is_load;
  } fwd_entry_t;

endpackage

// File: rtl/operand_fwd_ctrl_if.sv
// Bundle between the ID stage and the forwarding controller.
//   ID-side inputs : id_valid_in, id_rn_in, id_rm_in, id_rn_used_in, id_rm_used_in,
//                    id_rd_in, id_wr_en_in, id_is_load_in, flush_in
//   Controller outs: sel_a_out, sel_b_out, ex_valid_out, stall_out
//   master = pipeline side driving ID info, slave = forwarding controller.
interface operand_fwd_ctrl_if;
  import arm_pipe_pkg::*;

  logic                  id_valid_in;
  logic [REG_ADDR_W-1:0] id_rn_in;
  logic [REG_ADDR_W-1:0] id_rm_in;
  logic                  id_rn_used_in;
  logic                  id_rm_used_in;
  logic [REG_ADDR_W-1:0] id_rd_in;
  logic                  id_wr_en_in;
  logic                  id_is_load_in;
  logic                  flush_in;
  logic [1:0]            sel_a_out;
  logic [1:0]            sel_b_out;
  logic                  ex_valid_out;
  logic                  stall_out;

  modport master (
    output id_valid_in, id_rn_in, id_rm_in, id_rn_used_in, id_rm_used_in,
           id_rd_in, id_wr_en_in, id_is_load_in, flush_in,
    input  sel_a_out, sel_b_out, ex_valid_out, stall_out
  );

  modport slave (
    input  id_valid_in, id_rn_in, id_rm_in, id_rn_used_in, id_rm_used_in,
           id_rd_in, id_wr_en_in, id_is_load_in, flush_in,
    output sel_a_out, sel_b_out, ex_valid_out, stall_out
  );

endinterface

// File: rtl/fwd_src_sel.sv
// Combinational forwarding select for one source operand.
//   used_i : operand is read from the register file
//   src_i  : source register number
//   ex_i   : producer currently in EX (youngest)
//   mem_i  : producer currently in MEM
//   sel_o  : operand mux select (regfile / EX-MEM / MEM-WB / PC)
module fwd_src_sel
  import arm_pipe_pkg::*;
(
  input  logic                  used_i,
  input  logic [REG_ADDR_W-1:0] src_i,
  input  fwd_entry_t            ex_i,
  input  fwd_entry_t            mem_i,
  output logic [1:0]            sel_o
);

  // Youngest producer wins: EX is checked before MEM.
  always_comb begin
    sel_o = SEL_REGFILE;
    if (!used_i)                              sel_o = SEL_REGFILE;
    else if (src_i == PC_REG)                 sel_o = SEL_PC;
    else if (ex_i.valid  && ex_i.rd  == src_i) sel_o = SEL_EXMEM;
    else if (mem_i.valid && mem_i.rd == src_i) sel_o = SEL_MEMWB;
    else                                      sel_o = SEL_REGFILE;
  end

endmodule

// File: rtl/operand_fwd_ctrl.sv
// Operand-forwarding controller for the EX stage.
// Tracks the destination of the instructions in EX and MEM, compares them with
// the ID sources and registers the operand-A (Rn) / operand-B (Rm) mux selects
// into EX. Raises a one-cycle load-use stall when a load in EX feeds ID.
//   clk_in   : pipeline clock, rising edge
//   rst_n_in : asynchronous active-low reset
//   fwd_if   : ID-stage info in, selects / ex_valid / stall out (slave side)
module operand_fwd_ctrl
  import arm_pipe_pkg::*;
(
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  operand_fwd_ctrl_if.slave        fwd_if
);

  fwd_entry_t ex_q, ex_d;
  fwd_entry_t mem_q, mem_d;
  logic [1:0] sel_a_q, sel_a_d;
  logic [1:0] sel_b_q, sel_b_d;
  logic       ex_valid_q, ex_valid_d;
  logic [1:0] sel_a_c, sel_b_c;
  logic       stall_c;
  logic       issue_c;

  fwd_src_sel u_sel_a (
    .used_i (fwd_if.id_rn_used_in),
    .src_i  (fwd_if.id_rn_in),
    .ex_i   (ex_q),
    .mem_i  (mem_q),
    .sel_o  (sel_a_c)
  );

  fwd_src_sel u_sel_b (
    .used_i (fwd_if.id_rm_used_in),
    .src_i  (fwd_if.id_rm_in),
    .ex_i   (ex_q),
    .mem_i  (mem_q),
    .sel_o  (sel_b_c)
  );

  // Flush masks the stall: the ID instruction is being killed anyway.
  always_comb begin
    stall_c = fwd_if.id_valid_in && !fwd_if.flush_in && ex_q.valid && ex_q.is_load &&
              ((fwd_if.id_rn_used_in && (fwd_if.id_rn_in == ex_q.rd)) ||
               (fwd_if.id_rm_used_in && (fwd_if.id_rm_in == ex_q.rd)));
    issue_c = fwd_if.id_valid_in && !fwd_if.flush_in && !stall_c;
  end

  always_comb begin
    ex_d       = '0;
    ex_valid_d = 1'b0;
    sel_a_d    = SEL_REGFILE;
    sel_b_d    = SEL_REGFILE;
    mem_d      = ex_q;
    if (issue_c) begin
      // A PC write is a real instruction but never a forwarding source.
      ex_d.valid   = fwd_if.id_wr_en_in && (fwd_if.id_rd_in != PC_REG);
      ex_d.rd      = fwd_if.id_rd_in;
      ex_d.is_load = fwd_if.id_is_load_in;
      ex_valid_d   = 1'b1;
      sel_a_d      = sel_a_c;
      sel_b_d      = sel_b_c;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ex_q       <= '0;
      mem_q      <= '0;
      sel_a_q    <= SEL_REGFILE;
      sel_b_q    <= SEL_REGFILE;
      ex_valid_q <= 1'b0;
    end else begin
      ex_q       <= ex_d;
      mem_q      <= mem_d;
      sel_a_q    <= sel_a_d;
      sel_b_q    <= sel_b_d;
      ex_valid_q <= ex_valid_d;
    end
  end

  assign fwd_if.sel_a_out    = sel_a_q;
  assign fwd_if.sel_b_out    = sel_b_q;
  assign fwd_if.ex_valid_out = ex_valid_q;
  assign fwd_if.stall_out    = stall_c;

endmodule

// File: tb/tb_operand_fwd_ctrl.sv
// Self-checking bench for operand_fwd_ctrl: directed vector table, mid-stream
// reset sequence, and randomized traffic against a pipeline-history model.
module tb_operand_fwd_ctrl;

  typedef struct packed {
    logic       valid;
    logic [3:0] rn;
    logic [3:0] rm;
    logic       rnu;
    logic       rmu;
    logic [3:0] rd;
    logic       wr;
    logic       ld;
  } instr_t;

  typedef struct packed {
    instr_t     i;
    logic       fl;
    logic       es;
    logic [1:0] ea;
    logic [1:0] eb;
    logic       ev;
  } vec_t;

  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  always #5 clk_in = ~clk_in;

  operand_fwd_ctrl_if bus ();

  operand_fwd_ctrl dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .fwd_if   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: the two most recent cycles' worth of issued instructions.
  instr_t m_ex = '0;
  instr_t m_mem = '0;
  logic   obs_stall, obs_ev;
  logic [1:0] obs_a, obs_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic instr_t mk(input logic v, input int rn, input int rm, input logic rnu,
                                input logic rmu, input int rd, input logic wr, input logic ld);
    instr_t t;
    t.valid = v; t.rn = 4'(rn); t.rm = 4'(rm); t.rnu = rnu; t.rmu = rmu;
    t.rd = 4'(rd); t.wr = wr; t.ld = ld;
    return t;
  endfunction

  function automatic logic writes(input instr_t p, input logic [3:0] r);
    return p.valid && p.wr && (p.rd == r) && (r != 4'd15);
  endfunction

  function automatic logic [1:0] m_sel(input logic used, input logic [3:0] src);
    instr_t prod [2];
    prod[0] = m_ex;
    prod[1] = m_mem;
    if (!used) return 2'b00;
    if (src == 4'd15) return 2'b11;
    for (int k = 0; k < 2; k++)
      if (writes(prod[k], src)) return (k == 0) ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  function automatic logic m_stall(input instr_t i, input logic fl);
    logic load_ex, reads;
    load_ex = writes(m_ex, m_ex.rd) && m_ex.ld;
    reads   = (i.rnu && i.rn == m_ex.rd) || (i.rmu && i.rm == m_ex.rd);
    return i.valid && !fl && load_ex && reads;
  endfunction

  task automatic drive(input instr_t i, input logic fl);
    bus.id_valid_in   = i.valid;
    bus.id_rn_in      = i.rn;
    bus.id_rm_in      = i.rm;
    bus.id_rn_used_in = i.rnu;
    bus.id_rm_used_in = i.rmu;
    bus.id_rd_in      = i.rd;
    bus.id_wr_en_in   = i.wr;
    bus.id_is_load_in = i.ld;
    bus.flush_in      = fl;
  endtask

  // Called at posedge+1: drive, check stall mid-cycle, clock, check EX outputs.
  task automatic step(input instr_t i, input logic fl);
    logic es, issue;
    logic [1:0] ea, eb;
    drive(i, fl);
    #3;
    es = m_stall(i, fl);
    obs_stall = bus.stall_out;
    chk("stall", 32'(obs_stall), 32'(es));
    issue = i.valid && !fl && !es;
    ea = issue ? m_sel(i.rnu, i.rn) : 2'b00;
    eb = issue ? m_sel(i.rmu, i.rm) : 2'b00;
    @(posedge clk_in);
    #1;
    m_mem = m_ex;
    m_ex  = issue ? i : '0;
    obs_a = bus.sel_a_out;
    obs_b = bus.sel_b_out;
    obs_ev = bus.ex_valid_out;
    chk("sel_a", 32'(obs_a), 32'(ea));
    chk("sel_b", 32'(obs_b), 32'(eb));
    chk("ex_valid", 32'(obs_ev), 32'(issue));
  endtask

  function automatic vec_t mv(input instr_t i, input logic fl, input logic es,
                              input int ea, input int eb, input logic ev);
    vec_t v;
    v.i = i; v.fl = fl; v.es = es; v.ea = 2'(ea); v.eb = 2'(eb); v.ev = ev;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    instr_t nop, r;
    nop = '0;
    // ADD r1 ; ADD r2,r1,r3 ; NOP
    tbl.push_back(mv(mk(1,2,3,1,1,1,1,0),  0,0,0,0,1));
    tbl.push_back(mv(mk(1,1,3,1,1,2,1,0),  0,0,1,0,1));
    tbl.push_back(mv(nop,                  0,0,0,0,0));
    // ADD r1 ; NOP ; SUB r4,r5,r1 -> MEM forward
    tbl.push_back(mv(mk(1,8,9,1,1,1,1,0),  0,0,0,0,1));
    tbl.push_back(mv(nop,                  0,0,0,0,0));
    tbl.push_back(mv(mk(1,5,1,1,1,4,1,0),  0,0,0,2,1));
    // r1 in both EX and MEM -> EX wins
    tbl.push_back(mv(mk(1,8,9,1,1,1,1,0),  0,0,0,0,1));
    tbl.push_back(mv(mk(1,8,9,1,1,1,1,0),  0,0,0,0,1));
    tbl.push_back(mv(mk(1,1,1,1,1,10,1,0), 0,0,1,1,1));
    // LDR r6 ; ADD r7,r6,r6 -> one stall, bubble, then 10/10
    tbl.push_back(mv(mk(1,8,0,1,0,6,1,1),  0,0,0,0,1));
    tbl.push_back(mv(mk(1,6,6,1,1,7,1,0),  0,1,0,0,0));
    tbl.push_back(mv(mk(1,6,6,1,1,7,1,0),  0,0,2,2,1));
    // write r15 ; read r15 -> PC select, write not tracked
    tbl.push_back(mv(mk(1,8,0,1,0,15,1,0), 0,0,0,0,1));
    tbl.push_back(mv(mk(1,15,15,1,1,2,1,0),0,0,3,3,1));
    // LDR r6 ; load-use under flush ; load now in MEM forwards
    tbl.push_back(mv(mk(1,8,0,1,0,6,1,1),  0,0,0,0,1));
    tbl.push_back(mv(mk(1,6,6,1,1,7,1,0),  1,0,0,0,0));
    tbl.push_back(mv(mk(1,6,8,1,1,9,1,0),  0,0,2,0,1));

    drive(nop, 1'b0);
    #2;
    chk("reset_sel_a", 32'(bus.sel_a_out), 32'd0);
    chk("reset_sel_b", 32'(bus.sel_b_out), 32'd0);
    chk("reset_ex_valid", 32'(bus.ex_valid_out), 32'd0);
    chk("reset_stall", 32'(bus.stall_out), 32'd0);
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;

    foreach (tbl[k]) begin
      step(tbl[k].i, tbl[k].fl);
      chk($sformatf("vec%0d_stall", k), 32'(obs_stall), 32'(tbl[k].es));
      chk($sformatf("vec%0d_sel_a", k), 32'(obs_a), 32'(tbl[k].ea));
      chk($sformatf("vec%0d_sel_b", k), 32'(obs_b), 32'(tbl[k].eb));
      chk($sformatf("vec%0d_ex_valid", k), 32'(obs_ev), 32'(tbl[k].ev));
    end

    // Mid-stream reset while a load-use is pending.
    step(mk(1,8,9,1,1,5,1,0), 1'b0);
    step(mk(1,5,0,1,0,6,1,1), 1'b0);
    chk("pre_rst_sel_a", 32'(bus.sel_a_out), 32'd1);
    drive(mk(1,6,6,1,1,7,1,0), 1'b0);
    #2;
    chk("pre_rst_stall", 32'(bus.stall_out), 32'd1);
    rst_n_in = 1'b0;
    #1;
    chk("mid_rst_sel_a", 32'(bus.sel_a_out), 32'd0);
    chk("mid_rst_ex_valid", 32'(bus.ex_valid_out), 32'd0);
    chk("mid_rst_stall", 32'(bus.stall_out), 32'd0);
    m_ex = '0;
    m_mem = '0;
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    step(mk(1,6,5,1,1,8,1,0), 1'b0);
    chk("post_rst_sel_a", 32'(obs_a), 32'd0);
    chk("post_rst_sel_b", 32'(obs_b), 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      r.valid = ($urandom_range(0, 9) < 8);
      r.rn    = ($urandom_range(0, 4) == 4) ? 4'd15 : 4'($urandom_range(1, 3));
      r.rm    = ($urandom_range(0, 4) == 4) ? 4'd15 : 4'($urandom_range(1, 3));
      r.rd    = ($urandom_range(0, 5) == 5) ? 4'd15 : 4'($urandom_range(1, 3));
      r.rnu   = 1'($urandom_range(0, 1));
      r.rmu   = 1'($urandom_range(0, 1));
      r.wr    = ($urandom_range(0, 3) != 0);
      r.ld    = ($urandom_range(0, 2) == 0);
      step(r, ($urandom_range(0, 9) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
